adc_acq_ctrl: RTL
=================

ADC_ACQ_CTRL -- requirements
Module: adc_acq_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of analog-mux channels; legal range 2..8.
REQ-002 Parameter SETTLE_CYC, default 64: clk cycles of mux settling before a sample is accepted.
REQ-003 Parameter TIMEOUT_CYC, default 4096: clk cycles to wait for adc_drdy before the channel is abandoned.
REQ-004 Parameter FIFO_DEPTH, default 4: output FIFO entries; power of two.
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 enable  input  1  level; 1 = run the channel scan.
REQ-008 ch_mask  input  NUM_CH  1 = channel included in the scan.
REQ-009 adc_drdy  input  1  one-cycle pulse from the ADC receiver: adc_data is valid.
REQ-010 adc_data  input  16  sample word from the ADC receiver.
REQ-011 mux_sel  output  clog2(NUM_CH)  external analog-mux select.
REQ-012 sample_valid  output  1  FIFO head valid.
REQ-013 sample_ready  input  1  consumer accepts the head when valid and ready are both 1.
REQ-014 sample_data  output  16  FIFO head data.
REQ-015 sample_ch  output  clog2(NUM_CH)  channel tag of the FIFO head.
REQ-016 busy  output  1  FSM is not IDLE.
REQ-017 timeout_err  output  1  one-cycle pulse on channel timeout.
REQ-018 overflow  output  1  sticky; a sample was dropped because the FIFO was full.

Function
REQ-019 FSM states: IDLE, SELECT, SETTLE, WAIT, STORE.
REQ-020 IDLE -> SELECT when enable=1 and ch_mask!=0; otherwise remain in IDLE.
REQ-021 SELECT: mux_sel takes the next channel whose mask bit is set, searching upward from (current+1) and wrapping modulo NUM_CH; the first pass after reset starts the search at channel 0; next state is SETTLE.
REQ-022 SETTLE: count exactly SETTLE_CYC cycles, then go to WAIT; any adc_drdy received in SETTLE is ignored.
REQ-023 WAIT: the first adc_drdy captures adc_data and the FSM goes to STORE.
REQ-024 WAIT: if TIMEOUT_CYC cycles elapse with no adc_drdy, pulse timeout_err for one cycle and go to SELECT; no FIFO write occurs.
REQ-025 STORE: push {mux_sel, captured data} into the FIFO in a single cycle, then go to SELECT.
REQ-026 STORE with the FIFO full: drop the sample, set overflow, and continue to SELECT.
REQ-027 FIFO: first-in first-out; push latency 1 cycle (an entry pushed in cycle N is visible at the head in cycle N+1).
REQ-028 Simultaneous push and pop on a full FIFO: the pop is honoured first, the push succeeds, and overflow is not set.
REQ-029 sample_data and sample_ch are held stable while sample_valid=1 and sample_ready=0.
REQ-030 If enable falls in any state other than IDLE: go to IDLE on the next edge and discard any partial sample; FIFO contents are retained and the consumer can still drain them.
REQ-031 If ch_mask changes mid-scan, the new value is applied at the next SELECT.
REQ-032 If ch_mask becomes 0 while running: at the next SELECT, go to IDLE.

Reset
REQ-033 While reset=1: state=IDLE; mux_sel=0; FIFO empty; sample_valid=0; sample_data=0; sample_ch=0; busy=0; timeout_err=0; overflow=0; all counters=0.
REQ-034 overflow is cleared only by reset.

Configuration
REQ-035 Macro ADC_ACQ_CTRL_AVG_EN defined: WAIT accumulates 4 adc_drdy samples in an 18-bit unsigned sum; the timeout counter restarts after each sample; STORE pushes sum[17:2] (truncated).
REQ-036 ADC_ACQ_CTRL_AVG_EN defined, timeout before the 4th sample: the partial sum is discarded and the channel is handled as a timeout (REQ-024).
REQ-037 Macro ADC_ACQ_CTRL_AVG_EN undefined: a single sample per channel is stored, and no accumulator is synthesized.

Structure
REQ-038 Package adc_acq_pkg holds: the FSM state enum, default parameter constants, and the FIFO entry struct {ch, data}.
REQ-039 The FIFO is implemented as sub-module adc_acq_fifo, parameterized by depth and width; the full/empty logic lives inside it.

Verification
REQ-040 ch_mask=4'b1011, enable=1, each drdy data = 16'h1000+ch -> mux_sel sequence 0,1,3,0; FIFO receives (0,1000),(1,1001),(3,1003).
REQ-041 Channel 1 never drdy -> timeout_err pulses TIMEOUT_CYC cycles after entering WAIT; the scan proceeds to channel 3; no channel-1 entry is pushed.
REQ-042 sample_ready=0, 6 channels sampled -> 4 entries held, overflow=1 after the 5th STORE; draining yields the first 4 samples in order.
REQ-043 enable dropped during SETTLE -> busy=0 on the next cycle, no push, and the FIFO remains drainable.
REQ-044 AVG_EN, samples 100,101,102,103 -> sample_data=101; reset asserted mid-WAIT -> all outputs return to the REQ-033 values immediately.
REQ-045 adc_drdy pulsed during SETTLE and then once in WAIT -> only the WAIT sample is stored.

Source files
------------

// File: rtl/adc_acq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : adc_acq_pkg
//  Description : Shared types and constants for the ADC acquisition
//                controller: FSM state encoding, default parameter values,
//                the FIFO entry layout and the masked round-robin channel
//                search helper.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_acq_pkg;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_SETTLE_CYC  = 64;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;

  localparam int unsigned SAMPLE_W = 16;
  // Widest channel tag needed for the largest legal channel count (8).
  localparam int unsigned MAX_CH_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STORE  = 3'd4
  } acq_state_e;

  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic [SAMPLE_W-1:0] data;
  } fifo_entry_t;

  // First channel with its mask bit set, searching upward and wrapping
  // modulo num_ch. The search starts at channel 0 when from_zero is set,
  // otherwise at cur+1. With an empty mask the current channel is returned.
  function automatic logic [MAX_CH_W-1:0] next_ch(
    input logic [7:0]          mask,
    input logic [MAX_CH_W-1:0] cur,
    input logic                from_zero,
    input int unsigned         num_ch
  );
    logic [3:0]          start;
    logic [3:0]          cand;
    logic                found;
    logic [MAX_CH_W-1:0] result;
    start  = from_zero ? 4'd0 : ({1'b0, cur} + 4'd1);
    found  = 1'b0;
    result = cur;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < num_ch) begin
        cand = start + 4'(i);
        // start <= num_ch and i < num_ch, so one subtraction wraps fully.
        if (cand >= 4'(num_ch)) begin
          cand = cand - 4'(num_ch);
        end
        if (!found && mask[cand[2:0]]) begin
          found  = 1'b1;
          result = cand[2:0];
        end
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_acq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : adc_acq_fifo
//  Description : Synchronous first-word-fall-through FIFO for acquired
//                samples. A word pushed in cycle N is at the head in N+1.
//                When full, a simultaneous pop frees the slot so the push
//                still succeeds.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk      in   clock, rising edge
//    reset    in   asynchronous, active-high
//    push     in   write request
//    pop      in   read request (ignored when empty)
//    wr_data  in   WIDTH  write word
//    rd_data  out  WIDTH  head word
//    full     out  no free slot
//    empty    out  no valid word
//    push_ok  out  the push in this cycle is accepted
// ============================================================================
module adc_acq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             push_ok
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_acq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adc_acq_ctrl
//  Description : Multi-channel ADC acquisition controller. Scans the enabled
//                analog-mux channels round-robin, waits for mux settling,
//                captures one ADC sample per channel (or the truncated mean
//                of four when averaging is built in) and queues
//                {channel, sample} in an output FIFO.
//  Revision    : 1.0  initial release
//
//  Build option
//    ADC_ACQ_CTRL_AVG_EN  defined: average 4 samples per channel
//
//  Ports
//    clk           in   clock, rising edge
//    reset         in   asynchronous, active-high
//    enable        in   level, run the scan
//    ch_mask       in   NUM_CH  channels included in the scan
//    adc_drdy      in   one-cycle pulse, adc_data valid
//    adc_data      in   16      ADC sample word
//    mux_sel       out  CH_W    analog-mux select
//    sample_valid  out  FIFO head valid
//    sample_ready  in   consumer accepts head
//    sample_data   out  16      FIFO head sample
//    sample_ch     out  CH_W    FIFO head channel tag
//    busy          out  FSM not idle
//    timeout_err   out  one-cycle pulse on channel timeout
//    overflow      out  sticky, a sample was dropped on a full FIFO
// ============================================================================
module adc_acq_ctrl
  import adc_acq_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  localparam int unsigned CH_W       = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic                adc_drdy,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic [CH_W-1:0]     mux_sel,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic [CH_W-1:0]     sample_ch,
  output logic                busy,
  output logic                timeout_err,
  output logic                overflow
);

  // One counter serves both the settle and the timeout phase.
  localparam int unsigned CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  acq_state_e          state_q, state_d;
  logic [CH_W-1:0]     mux_sel_q, mux_sel_d;
  logic                first_q, first_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                timeout_err_q, timeout_err_d;
  logic                overflow_q, overflow_d;

`ifdef ADC_ACQ_CTRL_AVG_EN
  logic [17:0] acc_q, acc_d;
  logic [1:0]  nsamp_q, nsamp_d;
  logic [17:0] acc_sum;
  assign acc_sum = acc_q + 18'(adc_data);
`endif

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push_ok;
  fifo_entry_t     fifo_wr;
  fifo_entry_t     fifo_head;
  logic [CH_W-1:0] next_sel;
  logic            unused_head_ch;

  assign next_sel = CH_W'(next_ch(8'(ch_mask), MAX_CH_W'(mux_sel_q), first_q, NUM_CH));

  always_comb begin
    state_d       = state_q;
    mux_sel_d     = mux_sel_q;
    first_d       = first_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    timeout_err_d = 1'b0;
    overflow_d    = overflow_q;
    fifo_push     = 1'b0;
`ifdef ADC_ACQ_CTRL_AVG_EN
    acc_d         = acc_q;
    nsamp_d       = nsamp_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable && (ch_mask != '0)) begin
          state_d = ST_SELECT;
        end
      end

      ST_SELECT: begin
        cnt_d = '0;
        if (ch_mask == '0) begin
          state_d = ST_IDLE;
        end else begin
          mux_sel_d = next_sel;
          first_d   = 1'b0;
          state_d   = ST_SETTLE;
        end
      end

      // adc_drdy is deliberately not looked at while the mux settles.
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (adc_drdy) begin
          cnt_d = '0;
`ifdef ADC_ACQ_CTRL_AVG_EN
          if (nsamp_q == 2'd3) begin
            data_d  = 16'(acc_sum >> 2);
            acc_d   = '0;
            nsamp_d = '0;
            state_d = ST_STORE;
          end else begin
            acc_d   = acc_sum;
            nsamp_d = nsamp_q + 2'd1;
          end
`else
          data_d  = adc_data;
          state_d = ST_STORE;
`endif
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          state_d       = ST_SELECT;
`ifdef ADC_ACQ_CTRL_AVG_EN
          acc_d         = '0;
          nsamp_d       = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STORE: begin
        fifo_push = 1'b1;
        if (!fifo_push_ok) begin
          overflow_d = 1'b1;
        end
        state_d = ST_SELECT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping enable abandons whatever the channel was doing, including a
    // pending store; queued FIFO entries stay available to the consumer.
    if (!enable && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      cnt_d         = '0;
      timeout_err_d = 1'b0;
      fifo_push     = 1'b0;
      overflow_d    = overflow_q;
`ifdef ADC_ACQ_CTRL_AVG_EN
      acc_d         = '0;
      nsamp_d       = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mux_sel_q     <= '0;
      first_q       <= 1'b1;
      cnt_q         <= '0;
      data_q        <= '0;
      timeout_err_q <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef ADC_ACQ_CTRL_AVG_EN
      acc_q         <= '0;
      nsamp_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mux_sel_q     <= mux_sel_d;
      first_q       <= first_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      timeout_err_q <= timeout_err_d;
      overflow_q    <= overflow_d;
`ifdef ADC_ACQ_CTRL_AVG_EN
      acc_q         <= acc_d;
      nsamp_q       <= nsamp_d;
`endif
    end
  end

  assign fifo_wr.ch   = MAX_CH_W'(mux_sel_q);
  assign fifo_wr.data = data_q;
  assign fifo_pop     = sample_valid && sample_ready;

  adc_acq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (fifo_push_ok)
  );

  // The stored tag is sized for 8 channels; upper bits are always zero here.
  assign unused_head_ch = ^{fifo_head.ch, fifo_full};

  assign mux_sel      = mux_sel_q;
  assign sample_valid = !fifo_empty;
  assign sample_data  = fifo_head.data;
  assign sample_ch    = fifo_head.ch[CH_W-1:0];
  assign busy         = (state_q != ST_IDLE);
  assign timeout_err  = timeout_err_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire
